// File: rtl/vga_pkg.sv
// Shared timing defaults, colour constants and helpers for the VGA scan path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   - default 640x480@60 timing constants at 25 MHz pixel rate (from 50 MHz)
//   - derived defaults: H/V totals and sync start/last positions
//   - rgb_t packed 12-bit colour and the colour constants used by the compositor
//   - in_range(): inclusive range compare on 10-bit scan coordinates
package vga_pkg;

    // Default timing, in pixels (horizontal) and lines (vertical).
    localparam int PIX_DIV_DEF   = 2;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    // Derived defaults (800 x 525 total, hsync 656..751, vsync 490..491).
    localparam int H_TOTAL_DEF      = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF      = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
    localparam int H_SYNC_LAST_DEF  = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
    localparam int V_SYNC_LAST_DEF  = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    // Scan coordinates are unsigned 10-bit throughout.
    localparam int COORD_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t RGB_WHITE = 12'hFFF;
    localparam rgb_t RGB_RED   = 12'hF00;
    localparam rgb_t RGB_BLUE  = 12'h00F;
    localparam rgb_t RGB_GREY  = 12'h888;
    localparam rgb_t RGB_BLACK = 12'h000;

    // Inclusive range test; all operands are full-width, no wrap-around.
    function automatic logic in_range(
        input logic [COORD_W-1:0] pos,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA scan timing: pixel-rate divider, h/v counters, frame strobe, visible flag, raw syncs.
// Latency: pix_en/frame_tick/counters registered; video_on and raw syncs combinational from counters.
// Backpressure: none; free-running scan, consumers must keep pace with pix_en.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   hsp, vsp            scan position, 0..H_total-1 / 0..V_total-1
//   pix_en              one-clock pixel strobe, every PIX_DIV clocks
//   frame_tick          one clock, the first clock in which (hsp,vsp) reads (0,0)
//   video_on            hsp/vsp inside the visible area
//   hsync_raw/vsync_raw active-low syncs for the current hsp/vsp (not yet aligned)
module vga_timing
    import vga_pkg::*;
#(
    parameter int PIX_DIV   = PIX_DIV_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] hsp,
    output logic [COORD_W-1:0] vsp,
    output logic               pix_en,
    output logic               frame_tick,
    output logic               video_on,
    output logic               hsync_raw,
    output logic               vsync_raw
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS_END    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_END    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] H_SYNC_START = COORD_W'(H_VISIBLE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_LAST  = COORD_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_SYNC_START = COORD_W'(V_VISIBLE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_LAST  = COORD_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    // PIX_DIV = 1 is not supported (the hit-flag window would be empty);
    // the width guard only keeps elaboration legal.
    localparam int                DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             div_wrap;

    assign div_wrap = (div == DIV_LAST);

    // pix_en is registered from the divider, so after reset release the first
    // strobe is high in the second clock. Counters step at the end of a strobe
    // clock, which leaves the rest of the pixel period for the hit-flag
    // producers to answer for the new coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            pix_en     <= 1'b0;
            hsp        <= '0;
            vsp        <= '0;
            frame_tick <= 1'b0;
        end else begin
            div        <= div_wrap ? '0 : div + DIV_W'(1);
            pix_en     <= div_wrap;
            frame_tick <= 1'b0;
            if (pix_en) begin
                if (hsp == H_LAST) begin
                    hsp <= '0;
                    if (vsp == V_LAST) begin
                        vsp        <= '0;
                        // Raised together with the wrap so it is high exactly
                        // in the first clock showing (0,0); reset never sets it.
                        frame_tick <= 1'b1;
                    end else begin
                        vsp <= vsp + COORD_W'(1);
                    end
                end else begin
                    hsp <= hsp + COORD_W'(1);
                end
            end
        end
    end

    assign video_on  = (hsp < H_VIS_END) && (vsp < V_VIS_END);
    assign hsync_raw = ~in_range(hsp, H_SYNC_START, H_SYNC_LAST);
    assign vsync_raw = ~in_range(vsp, V_SYNC_START, V_SYNC_LAST);

endmodule

// File: rtl/vga_display.sv
// VGA scan generator and pixel compositor: drives hsp/vsp to the game objects, turns their hit flags into RGB.
// Latency: coordinates at pixel strobe N -> registered RGB/hsync/vsync at strobe N+1.
// Backpressure: none; hit flags must be valid from one clock after a coordinate change until the next pix_en.
//
// Ports:
//   clk, rst                   system clock (50 MHz), synchronous active-high reset
//   ball_on, p1_on, p2_on      per-pixel hit flags from the ball / right paddle / left paddle
//   hsp, vsp                   current scan position
//   pix_en, frame_tick         pixel strobe and start-of-frame strobe
//   video_on                   current scan position is visible
//   hsync, vsync               active-low syncs, aligned with RGB
//   red, green, blue           4-bit colour channels
// Build option: define VGA_BORDER_EN to draw a grey frame border and centre line.
module vga_display
    import vga_pkg::*;
#(
    parameter int PIX_DIV   = PIX_DIV_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ball_on,
    input  logic               p1_on,
    input  logic               p2_on,
    output logic [COORD_W-1:0] hsp,
    output logic [COORD_W-1:0] vsp,
    output logic               pix_en,
    output logic               frame_tick,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue
);

    logic hsync_raw;
    logic vsync_raw;
    logic border_hit;
    rgb_t pix_rgb;
    rgb_t rgb_q;

    vga_timing #(
        .PIX_DIV   (PIX_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .hsp        (hsp),
        .vsp        (vsp),
        .pix_en     (pix_en),
        .frame_tick (frame_tick),
        .video_on   (video_on),
        .hsync_raw  (hsync_raw),
        .vsync_raw  (vsync_raw)
    );

`ifdef VGA_BORDER_EN
    localparam logic [COORD_W-1:0] H_VIS_LAST = COORD_W'(H_VISIBLE - 1);
    localparam logic [COORD_W-1:0] V_VIS_LAST = COORD_W'(V_VISIBLE - 1);
    localparam logic [COORD_W-1:0] H_MID_L    = COORD_W'(H_VISIBLE / 2 - 1);
    localparam logic [COORD_W-1:0] H_MID_R    = COORD_W'(H_VISIBLE / 2);

    // Outer frame plus a two-pixel centre line; only matters in the visible
    // area because blanking overrides it below.
    assign border_hit = (hsp == '0) || (hsp == H_VIS_LAST) ||
                        (vsp == '0) || (vsp == V_VIS_LAST) ||
                        (hsp == H_MID_L) || (hsp == H_MID_R);
`else
    assign border_hit = 1'b0;
`endif

    // Colour for the pixel currently on hsp/vsp. Blanking is folded in here,
    // using video_on from the same pixel, so registering the result together
    // with the flags gives the same answer as gating with a delayed video_on.
    always_comb begin
        pix_rgb = RGB_BLACK;
        if (!video_on) begin
            pix_rgb = RGB_BLACK;
        end else if (ball_on) begin
            pix_rgb = RGB_WHITE;
        end else if (p1_on) begin
            pix_rgb = RGB_RED;
        end else if (p2_on) begin
            pix_rgb = RGB_BLUE;
        end else if (border_hit) begin
            pix_rgb = RGB_GREY;
        end
    end

    // One pixel-stage register for colour and syncs, loaded on the strobe
    // edge, i.e. the same edge at which the counters move on. Keeping the
    // syncs in this stage holds them aligned with the colour they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= RGB_BLACK;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            rgb_q <= pix_rgb;
            hsync <= hsync_raw;
            vsync <= vsync_raw;
        end
    end

    assign red   = rgb_q.r;
    assign green = rgb_q.g;
    assign blue  = rgb_q.b;

endmodule

// File: tb/tb_vga_display.sv
// Self-checking bench for vga_display, run at a reduced raster so whole frames fit in a short run.
// Expected outputs are computed from the clock count since reset release with plain arithmetic.
module tb_vga_display;

    localparam int D   = 2;
    localparam int HV  = 40;
    localparam int HFP = 4;
    localparam int HS  = 8;
    localparam int HBP = 6;
    localparam int VV  = 20;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT    = HV + HFP + HS + HBP;   // 58
    localparam int VT    = VV + VFP + VS + VBP;   // 27
    localparam int FRAME = HT * VT;               // 1566 pixels

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ball_on = 1'b0;
    logic       p1_on = 1'b0;
    logic       p2_on = 1'b0;
    logic [9:0] hsp;
    logic [9:0] vsp;
    logic       pix_en;
    logic       frame_tick;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;

    vga_display #(
        .PIX_DIV(D), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .ball_on(ball_on), .p1_on(p1_on), .p2_on(p2_on),
        .hsp(hsp), .vsp(vsp), .pix_en(pix_en), .frame_tick(frame_tick),
        .video_on(video_on), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int c = 0;            // clock edges since reset release (0 while in reset)
    int seg_base = 0;     // scene index offset for the current reset segment
    bit [2:0] rnd [FRAME];
    int cnt_white [2];
    int cnt_red [2];
    int cnt_blue [2];
    int cnt_grey [2];
    int cnt_hlow = 0;
    int cnt_vlow = 0;
    int first_pix = -1;
    int ft_cycles [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, c);
        end
    endtask

    // Hit flags {ball,p1,p2} per scene and pixel.
    function automatic bit [2:0] scene(input int f, input int x, input int y);
        if (f == 0) return (x == 25 && y == 10) ? 3'b100 : 3'b000;
        if (f == 1) begin
            if (y == 5 && x == 30) return 3'b111;
            if (y == 5 && x == 31) return 3'b011;
            if (y == 5 && x == 32) return 3'b001;
            if (y == 5 && x == 50) return 3'b111;   // horizontal blanking
            return 3'b000;
        end
        return rnd[y * HT + x];
    endfunction

    function automatic int exp_rgb(input int f, input int x, input int y);
        bit [2:0] s;
        s = scene(f, x, y);
        if (!(x < HV && y < VV)) return 0;
        if (s[2]) return 'hFFF;
        if (s[1]) return 'hF00;
        if (s[0]) return 'h00F;
`ifdef VGA_BORDER_EN
        if (x == 0 || x == HV - 1 || y == 0 || y == VV - 1 || x == HV / 2 - 1 || x == HV / 2)
            return 'h888;
`endif
        return 0;
    endfunction

    // Edge cc moves the counters (pix_en was high in the clock before it).
    function automatic bit adv(input int cc);
        return cc >= 2 && ((cc - 1) % D) == 0;
    endfunction

    // Number of pixel steps taken after cc edges.
    function automatic int kof(input int cc);
        return (cc > 0) ? (cc - 1) / D : 0;
    endfunction

    task automatic drive_flags();
        int k, p;
        bit [2:0] s;
        k = kof(c);
        p = k % FRAME;
        if (rst || adv(c)) s = 3'($urandom_range(0, 7));   // outside the valid window
        else s = scene(seg_base + k / FRAME, p % HT, p / HT);
        ball_on = s[2];
        p1_on   = s[1];
        p2_on   = s[0];
    endtask

    task automatic compare();
        int k, p, q, qx, qy, f, e_rgb, e_hs, e_vs, a_rgb;
        k = kof(c);
        p = k % FRAME;
        check("hsp", int'(hsp), p % HT);
        check("vsp", int'(vsp), p / HT);
        check("pix_en", int'(pix_en), (c > 0 && c % D == 0) ? 1 : 0);
        check("frame_tick", int'(frame_tick), (adv(c) && p == 0) ? 1 : 0);
        check("video_on", int'(video_on), ((p % HT) < HV && (p / HT) < VV) ? 1 : 0);
        if (k == 0) begin
            e_rgb = 0; e_hs = 1; e_vs = 1; qx = 0; qy = 0; f = 0;
        end else begin
            q  = (k - 1) % FRAME;
            qx = q % HT;
            qy = q / HT;
            f  = seg_base + (k - 1) / FRAME;
            e_rgb = exp_rgb(f, qx, qy);
            e_hs  = (qx >= HV + HFP && qx < HV + HFP + HS) ? 0 : 1;
            e_vs  = (qy >= VV + VFP && qy < VV + VFP + VS) ? 0 : 1;
        end
        a_rgb = int'({red, green, blue});
        check("rgb", a_rgb, e_rgb);
        check("hsync", int'(hsync), e_hs);
        check("vsync", int'(vsync), e_vs);
        // Observed statistics for the first segment, set against literals later.
        if (seg_base == 0) begin
            if (pix_en && first_pix < 0) first_pix = c;
            if (frame_tick) ft_cycles.push_back(c);
            if (pix_en && k >= 1 && f < 2) begin
                if (a_rgb == 'hFFF) cnt_white[f]++;
                if (a_rgb == 'hF00) cnt_red[f]++;
                if (a_rgb == 'h00F) cnt_blue[f]++;
                if (a_rgb == 'h888) cnt_grey[f]++;
                if (f == 0 && !hsync) cnt_hlow++;
                if (f == 0 && !vsync) cnt_vlow++;
            end
        end
    endtask

    task automatic step(input bit rst_next);
        @(posedge clk);
        if (rst) c = 0; else c = c + 1;
        #1;
        rst = rst_next;
        drive_flags();
        @(negedge clk);
        compare();
    endtask

    initial begin
        foreach (rnd[i]) rnd[i] = 3'($urandom_range(0, 7));
        for (int i = 0; i < 2; i++) begin
            cnt_white[i] = 0; cnt_red[i] = 0; cnt_blue[i] = 0; cnt_grey[i] = 0;
        end

        repeat (3) step(1'b1);
        check("reset_hsp", int'(hsp), 0);
        check("reset_hsync", int'(hsync), 1);
        check("reset_vsync", int'(vsync), 1);
        check("reset_rgb", int'({red, green, blue}), 0);

        // Three frames plus a partial line; ends mid-line.
        repeat (3 * FRAME * D + 40) step(1'b0);

        check("first_pix_en_edge", first_pix, 2);
        check("frame_tick_count", ft_cycles.size(), 3);
        if (ft_cycles.size() >= 2) begin
            check("frame_tick_first", ft_cycles[0], 3133);
            check("frame_tick_spacing", ft_cycles[1] - ft_cycles[0], 3132);
        end
        check("f0_white", cnt_white[0], 1);
        check("f1_white", cnt_white[1], 1);
        check("f1_red", cnt_red[1], 1);
        check("f1_blue", cnt_blue[1], 1);
        check("hsync_low_pixels", cnt_hlow, 216);
        check("vsync_low_pixels", cnt_vlow, 116);
`ifdef VGA_BORDER_EN
        check("f0_grey", cnt_grey[0], 152);
`else
        check("f0_grey", cnt_grey[0], 0);
`endif

        // One-clock reset in the middle of a line.
        check("pre_reset_hsp_nonzero", (hsp != 0) ? 1 : 0, 1);
        step(1'b1);
        seg_base = 2;
        step(1'b0);
        check("mid_reset_hsp", int'(hsp), 0);
        check("mid_reset_vsp", int'(vsp), 0);
        check("mid_reset_hsync", int'(hsync), 1);
        check("mid_reset_vsync", int'(vsync), 1);
        check("mid_reset_frame_tick", int'(frame_tick), 0);

        repeat (FRAME * D + 100) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_display.md
# vga_display

Scan-side counterpart of the game objects. The block generates 640x480@60 VGA timing from the 50 MHz system clock and drives the `hsp`/`vsp` pixel coordinates consumed by the ball and paddle blocks. It takes back their per-pixel `*_on` hit flags and composes the registered RGB and sync outputs that go to the VGA pins, with the sync signals delayed to stay aligned with the colour data.

## Interface
Parameters:
- `PIX_DIV`, 2: system clocks per pixel (50 MHz -> 25 MHz).
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `ball_on`  in  1  ball hit flag for the current `hsp`/`vsp`; the producer registers it one clock after the coordinates change.
- `p1_on`  in  1  right paddle hit flag, same timing as `ball_on`.
- `p2_on`  in  1  left paddle hit flag, same timing as `ball_on`.
- `hsp`  out  10  horizontal scan position, 0..H_total-1.
- `vsp`  out  10  vertical scan position, 0..V_total-1.
- `pix_en`  out  1  one-clock pixel strobe.
- `frame_tick`  out  1  one-clock pulse at the start of each frame.
- `video_on`  out  1  high when `hsp`/`vsp` are inside the visible area.
- `hsync`  out  1  horizontal sync to the VGA pin, active-low.
- `vsync`  out  1  vertical sync to the VGA pin, active-low.
- `red`  out  4  red channel to the VGA pins.
- `green`  out  4  green channel to the VGA pins.
- `blue`  out  4  blue channel to the VGA pins.

## Operation
- Totals: H_total = 800, V_total = 525, computed from the parameters.
- Divider:
  - `div` counts 0..PIX_DIV-1 and wraps.
  - `pix_en` = (`div` == PIX_DIV-1), registered.
- Counters advance only in cycles where `pix_en` is high:
  - `hsp` increments each pixel and wraps 799 -> 0.
  - On that wrap, `vsp` increments; it wraps 524 -> 0.
- Frame start: `frame_tick` is high for exactly one clock, the clock in which (`hsp`,`vsp`) first read (0,0). Game logic may use it as its frame update strobe.
- `video_on` = `hsp` < 640 && `vsp` < 480, combinational from the counters.
- Sync regions (raw, before output alignment):
  - hsync is active (0) for `hsp` in 656..751.
  - vsync is active (0) for `vsp` in 490..491.
- Compositor: samples `*_on` on each `pix_en` clock. Priority, highest first:
  - `ball_on` -> white F/F/F.
  - `p1_on` -> red F/0/0.
  - `p2_on` -> blue 0/0/F.
  - border feature (see Configuration).
  - background black 0/0/0.
- Blanking: when the delayed `video_on` is 0, RGB is forced to 0 regardless of the hit flags.
- Arithmetic: all counters are unsigned 10-bit. Compares use full-width constants; there is no wrap-around arithmetic.

## Timing
- Reset values:
  - `div` = 0, `hsp` = 0, `vsp` = 0.
  - `pix_en` = 0, `frame_tick` = 0.
  - `hsync` = 1, `vsync` = 1.
  - RGB = 0.
- First `pix_en` occurs in the second clock after `rst` falls.
- Output latency: coordinates presented at pixel strobe N produce RGB, `hsync` and `vsync` at pixel strobe N+1.
- Sync alignment: `hsync`/`vsync` pass through one pixel-stage register so they stay aligned with RGB.
- Hit-flag window: `*_on` is valid from one clock after a coordinate change until the next `pix_en`. This holds for any PIX_DIV >= 2; PIX_DIV = 1 is unsupported.
- Reset mid-frame: all state returns to the reset values in the next clock. `frame_tick` does not pulse on reset.
- Wrap: the (799,524) -> (0,0) transition takes one pixel, with no extra cycle.

## Configuration
- `VGA_BORDER_EN` defined:
  - Visible pixels with `hsp` in {0,639} or `vsp` in {0,479} are grey 8/8/8.
  - Visible pixels with `hsp` in {319,320} are grey 8/8/8 (centre line).
  - The border sits below the object colours in priority.
- `VGA_BORDER_EN` undefined: those pixels show background black.

## Structure
- `vga_pkg` holds:
  - Default timing constants.
  - Derived H_total/V_total and the sync start/end values.
  - The colour constants (white, red, blue, grey, black) as 12-bit RGB.
- Sub-module `vga_timing` holds the divider, counters, `pix_en`, `frame_tick`, `video_on` and the raw sync signals.
- The top level holds the compositor and the output alignment registers.

## Test plan
- Reset, then run 2 frames: `pix_en` every 2nd clock; 800 pixels per line and 525 lines per frame; `frame_tick` spacing is 840000 clocks.
- Count sync widths: `hsync` is low for 96 pixels, starting at the pixel delivered for `hsp`=656. `vsync` is low for 2 lines, from `vsp`=490.
- Drive `ball_on`=1 at (`hsp`,`vsp`) = (320,240) only: RGB = F/F/F at the next `pix_en` and black elsewhere in the visible area.
- Drive `ball_on`, `p1_on` and `p2_on` all high at (600,100): output is white. Drop `ball_on`: output is red. Drive `p2_on` alone: output is blue.
- Drive all `*_on` high during blanking (`hsp` = 700): RGB = 0.
- Assert `rst` for 1 clock mid-line: `hsp`/`vsp` = 0 in the next clock, syncs high, no `frame_tick`.
- With `VGA_BORDER_EN`: pixel (0,0) is grey 8/8/8. Without it, pixel (0,0) is 0/0/0.
